// File: rtl/relu_lane_collector.sv
// relu_lane_collector: gathers four Pa-bit ReLU results, one per handshake,
// into a registered 4-lane word and hands it downstream.
//
// Ports:
//   clk, rst_n       clock (rising edge) and async active-low reset
//   flush            synchronous abort of a partially collected group
//   in_data/valid    ReLU result for lane sel, and its valid strobe
//   in_ready         collector can take in_data this cycle
//   sel              lane currently expected (drives upstream 4:1 selector)
//   out0..out3       collected lanes 0..3
//   out_valid        out0..out3 hold a complete group
//   out_ready        downstream consumes the group
//   group_cnt        completed groups handed off, mod 256
module relu_lane_collector #(
    parameter int Pa = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic [Pa-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [1:0]    sel,
    output logic [Pa-1:0] out0,
    output logic [Pa-1:0] out1,
    output logic [Pa-1:0] out2,
    output logic [Pa-1:0] out3,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    group_cnt
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [1:0] sel_n;
    logic [3:0] ld;
    logic       cnt_inc;
    logic       accept;

    // Ready depends only on state and flush, never on out_ready.
    assign in_ready  = (state == COLLECT) && !flush;
    assign accept    = in_valid && in_ready;
    // out_valid is a decode of the registered state, so it is glitch-free.
    assign out_valid = (state == HOLD);

    always_comb begin
        state_n = state;
        sel_n   = sel;
        ld      = 4'b0000;
        cnt_inc = 1'b0;
        unique case (state)
            COLLECT: begin
                if (flush) begin
                    sel_n = 2'd0;
                end else if (accept) begin
                    ld[sel] = 1'b1;
                    // 3 -> 0 wrap is natural in 2 bits
                    sel_n   = sel + 2'd1;
                    if (sel == 2'd3) begin
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                // flush is ignored here: a complete group is never dropped
                if (out_ready) begin
                    state_n = COLLECT;
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_n = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            sel       <= 2'd0;
            group_cnt <= 8'd0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            if (cnt_inc) begin
                group_cnt <= group_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0 <= '0;
            out1 <= '0;
            out2 <= '0;
            out3 <= '0;
        end else begin
            if (ld[0]) out0 <= in_data;
            if (ld[1]) out1 <= in_data;
            if (ld[2]) out2 <= in_data;
            if (ld[3]) out3 <= in_data;
        end
    end

endmodule

// File: tb/tb_relu_lane_collector.sv
// Testbench for relu_lane_collector: directed scenarios plus random traffic
// checked against a queue-based model of the collection behaviour.
module tb_relu_lane_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] sel;
    logic [7:0] out0, out1, out2, out3;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] group_cnt;

    relu_lane_collector #(.Pa(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out_valid(out_valid), .out_ready(out_ready),
        .group_cnt(group_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model: accepted bytes of the current group in a queue.
    logic [7:0] m_q[$];
    logic [7:0] m_grp[4];
    bit         m_held;
    logic [7:0] m_cnt;

    logic obs_ready;
    logic exp_ready;

    function automatic logic [31:0] m_word();
        return {m_grp[0], m_grp[1], m_grp[2], m_grp[3]};
    endfunction

    function automatic logic [1:0] m_sel();
        return 2'(m_q.size());
    endfunction

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < 4; i++) m_grp[i] = 8'h00;
        m_held = 0;
        m_cnt  = 8'h00;
    endtask

    // Drive one cycle; entered and left at posedge+1.
    task automatic cycle(input logic v, input logic [7:0] d,
                         input logic f, input logic r);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
        #1;
        obs_ready = in_ready;
        exp_ready = !m_held && !f;
        @(posedge clk);
        if (m_held) begin
            if (r) begin
                m_held = 0;
                m_cnt  = m_cnt + 8'd1;
            end
        end else if (f) begin
            m_q.delete();
        end else if (v) begin
            m_q.push_back(d);
            if (m_q.size() == 4) begin
                for (int i = 0; i < 4; i++) m_grp[i] = m_q[i];
                m_q.delete();
                m_held = 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        in_valid = 0; in_data = 0; flush = 0; out_ready = 0;
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1;
        @(posedge clk);
        #1;
        n_total++;
        if (sel !== 2'd0 || out_valid !== 1'b0) begin
            $display("FAIL reset_ctl: sel=%0d ov=%b exp 0 0", sel, out_valid);
        end else n_pass++;
        n_total++;
        if ({out0, out1, out2, out3} !== 32'h0) begin
            $display("FAIL reset_outs: got %h exp 0",
                     {out0, out1, out2, out3});
        end else n_pass++;
        n_total++;
        if (group_cnt !== 8'd0 || in_ready !== 1'b1) begin
            $display("FAIL reset_cnt: cnt=%0d rdy=%b exp 0 1",
                     group_cnt, in_ready);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (sel !== 2'(i)) begin
                $display("FAIL b2b_sel: got %0d exp %0d", sel, i);
            end else n_pass++;
            d = 8'(8'h11 * (i + 1));
            cycle(1, d, 0, 1);
        end
        n_total++;
        if (out_valid !== 1'b1 || sel !== 2'd0) begin
            $display("FAIL b2b_valid: ov=%b sel=%0d exp 1 0",
                     out_valid, sel);
        end else n_pass++;
        n_total++;
        if ({out0, out1, out2, out3} !== 32'h11223344) begin
            $display("FAIL b2b_data: got %h exp 11223344",
                     {out0, out1, out2, out3});
        end else n_pass++;
        cycle(0, 8'h00, 0, 1);
        n_total++;
        if (out_valid !== 1'b0 || group_cnt !== 8'd1) begin
            $display("FAIL b2b_handoff: ov=%b cnt=%0d exp 0 1",
                     out_valid, group_cnt);
        end else n_pass++;
    endtask

    task automatic test_stall_and_hold();
        logic [31:0] held;
        for (int i = 0; i < 8; i++) begin
            cycle(!i[0], 8'(8'hA0 + i / 2), 0, 0);
            n_total++;
            if (sel !== 2'(((i + 2) / 2) % 4)) begin
                $display("FAIL stall_sel: got %0d exp %0d",
                         sel, ((i + 2) / 2) % 4);
            end else n_pass++;
        end
        n_total++;
        if (out_valid !== 1'b1 ||
            {out0, out1, out2, out3} !== 32'hA0A1A2A3) begin
            $display("FAIL stall_grp: ov=%b got %h exp 1 a0a1a2a3",
                     out_valid, {out0, out1, out2, out3});
        end else n_pass++;
        held = {out0, out1, out2, out3};
        for (int i = 0; i < 10; i++) begin
            cycle(1'($urandom), 8'($urandom), 0, 0);
            n_total++;
            if (out_valid !== 1'b1 || obs_ready !== 1'b0 ||
                {out0, out1, out2, out3} !== held) begin
                $display("FAIL hold: ov=%b rdy=%b got %h exp 1 0 %h",
                         out_valid, obs_ready,
                         {out0, out1, out2, out3}, held);
            end else n_pass++;
        end
        cycle(0, 8'h00, 0, 1);
        n_total++;
        if (out_valid !== 1'b0 || group_cnt !== 8'd2) begin
            $display("FAIL hold_release: ov=%b cnt=%0d exp 0 2",
                     out_valid, group_cnt);
        end else n_pass++;
    endtask

    task automatic test_flush();
        cycle(1, 8'h01, 0, 1);
        cycle(1, 8'h02, 0, 1);
        cycle(1, 8'hFF, 1, 1);
        n_total++;
        if (sel !== 2'd0 || obs_ready !== 1'b0) begin
            $display("FAIL flush_sel: sel=%0d rdy=%b exp 0 0",
                     sel, obs_ready);
        end else n_pass++;
        for (int i = 0; i < 4; i++) cycle(1, 8'(8'h10 + i), 0, 1);
        n_total++;
        if (out_valid !== 1'b1 ||
            {out0, out1, out2, out3} !== 32'h10111213) begin
            $display("FAIL flush_grp: ov=%b got %h exp 1 10111213",
                     out_valid, {out0, out1, out2, out3});
        end else n_pass++;
        cycle(0, 8'h00, 0, 1);
    endtask

    task automatic test_flush_edges();
        for (int i = 0; i < 3; i++) cycle(1, 8'(8'h50 + i), 0, 1);
        cycle(1, 8'h5F, 1, 1);
        n_total++;
        if (out_valid !== 1'b0 || sel !== 2'd0) begin
            $display("FAIL flush_last: ov=%b sel=%0d exp 0 0",
                     out_valid, sel);
        end else n_pass++;
        for (int i = 0; i < 4; i++) cycle(1, 8'(8'h60 + i), 0, 0);
        cycle(1, 8'h77, 1, 0);
        n_total++;
        if (out_valid !== 1'b1 ||
            {out0, out1, out2, out3} !== 32'h60616263) begin
            $display("FAIL flush_hold: ov=%b got %h exp 1 60616263",
                     out_valid, {out0, out1, out2, out3});
        end else n_pass++;
        cycle(0, 8'h00, 0, 1);
        n_total++;
        if (group_cnt !== 8'd4) begin
            $display("FAIL flush_cnt: got %0d exp 4", group_cnt);
        end else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom), 8'($urandom),
                  ($urandom_range(0, 7) == 0),
                  1'($urandom));
            n_total++;
            if (obs_ready !== exp_ready || sel !== m_sel() ||
                out_valid !== m_held || group_cnt !== m_cnt) begin
                $display("FAIL rand_ctl: rdy=%b sel=%0d ov=%b cnt=%0d exp %b %0d %b %0d",
                         obs_ready, sel, out_valid, group_cnt,
                         exp_ready, m_sel(), m_held, m_cnt);
            end else n_pass++;
            if (m_held) begin
                n_total++;
                if ({out0, out1, out2, out3} !== m_word()) begin
                    $display("FAIL rand_data: got %h exp %h",
                             {out0, out1, out2, out3}, m_word());
                end else n_pass++;
            end
        end
    endtask

    task automatic test_wrap();
        int left;
        cycle(0, 8'h00, 1, 1);
        cycle(0, 8'h00, 1, 1);
        left = 256 - int'(m_cnt);
        for (int g = 0; g < left; g++) begin
            for (int i = 0; i < 4; i++) cycle(1, 8'($urandom), 0, 1);
            cycle(0, 8'h00, 0, 1);
        end
        n_total++;
        if (group_cnt !== 8'd0 || m_cnt !== 8'd0) begin
            $display("FAIL wrap: got %0d exp 0", group_cnt);
        end else n_pass++;
    endtask

    task automatic test_async_reset();
        cycle(1, 8'hC1, 0, 1);
        cycle(1, 8'hC2, 0, 1);
        n_total++;
        if (sel !== 2'd2) begin
            $display("FAIL pre_arst: sel=%0d exp 2", sel);
        end else n_pass++;
        #2;
        rst_n = 0;
        #1;
        n_total++;
        if (sel !== 2'd0 || out_valid !== 1'b0 || group_cnt !== 8'd0 ||
            {out0, out1, out2, out3} !== 32'h0) begin
            $display("FAIL async_rst: sel=%0d ov=%b cnt=%0d outs=%h exp 0",
                     sel, out_valid, group_cnt, {out0, out1, out2, out3});
        end else n_pass++;
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall_and_hold();
        test_flush();
        test_flush_edges();
        test_random();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
